demux1x4_16b_collect: RTL and testbench

DEMUX1X4_16B_COLLECT -- requirements
Module: demux1x4_16b_collect

---
 rtl/demux1x4_16b_collect.sv | 68 ++++++
 tb/tb_demux1x4_16b_collect.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/demux1x4_16b_collect.sv
// demux1x4_16b_collect: collects a 4-slot time-multiplexed sample stream into four frame registers
//   clk, rst (async, active high)   start: frame sync, din_valid/din: sample stream
//   y0..y3: last completed frame    s: next slot index
//   busy: collecting                frame_valid: one-cycle frame-complete pulse
//   err: sticky stray-sample flag, cleared by start
module demux1x4_16b_collect #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [1:0]       s,
  output logic             busy,
  output logic             frame_valid,
  output logic             err
);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state;
  logic [WIDTH-1:0] sh0, sh1, sh2;
  assign busy = (state == COLLECT);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s <= 2'd0;
      sh0 <= '0;
      sh1 <= '0;
      sh2 <= '0;
      y0 <= '0;
      y1 <= '0;
      y2 <= '0;
      y3 <= '0;
      frame_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (start) begin
        // restart wins over everything, including a coinciding slot-3 sample
        state <= COLLECT;
        err <= 1'b0;
        s <= din_valid ? 2'd1 : 2'd0;
        if (din_valid) sh0 <= din;
      end else if (din_valid) begin
        if (state == IDLE) err <= 1'b1;
        else if (s == 2'd3) begin
          // last slot goes straight to y3; the shadow slots publish together
          y0 <= sh0;
          y1 <= sh1;
          y2 <= sh2;
          y3 <= din;
          s <= 2'd0;
          state <= IDLE;
          frame_valid <= 1'b1;
        end else begin
          if (s == 2'd0) sh0 <= din;
          if (s == 2'd1) sh1 <= din;
          if (s == 2'd2) sh2 <= din;
          s <= s + 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_demux1x4_16b_collect.sv
// tb_demux1x4_16b_collect: table vectors, directed corner sequences and random stimulus against a frame-level model
module tb_demux1x4_16b_collect;
  localparam int W = 16;
  logic clk = 1'b0, rst, start, din_valid;
  logic [W-1:0] din, y0, y1, y2, y3;
  logic [1:0] s;
  logic busy, frame_valid, err;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  demux1x4_16b_collect #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .din_valid(din_valid), .din(din),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .s(s), .busy(busy),
    .frame_valid(frame_valid), .err(err)
  );
  bit m_in, m_fv, m_err;
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_y[4];
  function automatic void model_reset();
    m_in = 0;
    m_fv = 0;
    m_err = 0;
    m_q.delete();
    foreach (m_y[i]) m_y[i] = '0;
  endfunction
  function automatic void model_edge(bit st, bit v, logic [W-1:0] d);
    m_fv = 0;
    if (st) begin
      m_in = 1;
      m_err = 0;
      m_q.delete();
      if (v) m_q.push_back(d);
    end else if (v) begin
      if (!m_in) m_err = 1;
      else begin
        m_q.push_back(d);
        if (m_q.size() == 4) begin
          foreach (m_y[i]) m_y[i] = m_q[i];
          m_fv = 1;
          m_in = 0;
          m_q.delete();
        end
      end
    end
  endfunction
  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_all();
    chk("y0", y0, m_y[0]);
    chk("y1", y1, m_y[1]);
    chk("y2", y2, m_y[2]);
    chk("y3", y3, m_y[3]);
    chk("frame_valid", W'(frame_valid), W'(m_fv));
    chk("s", W'(s), W'(m_q.size()));
    chk("busy", W'(busy), W'(m_in));
    chk("err", W'(err), W'(m_err));
  endtask
  task automatic step(bit st, bit v, logic [W-1:0] d);
    start = st;
    din_valid = v;
    din = d;
    @(posedge clk);
    model_edge(st, v, d);
    #1;
    chk_all();
  endtask
  typedef struct {
    bit st, v;
    logic [W-1:0] d, y0, y1, y2, y3;
    bit fv;
    logic [1:0] s;
    bit busy, err;
  } vec_t;
  vec_t tbl[9];
  initial begin
    tbl[0] = '{1, 1, 16'h1111, 16'h0, 16'h0, 16'h0, 16'h0, 0, 2'd1, 1, 0};
    tbl[1] = '{0, 1, 16'h2222, 16'h0, 16'h0, 16'h0, 16'h0, 0, 2'd2, 1, 0};
    tbl[2] = '{0, 1, 16'h3333, 16'h0, 16'h0, 16'h0, 16'h0, 0, 2'd3, 1, 0};
    tbl[3] = '{0, 1, 16'h4444, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 2'd0, 0, 0};
    tbl[4] = '{0, 0, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 2'd0, 0, 0};
    tbl[5] = '{0, 1, 16'hDEAD, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 2'd0, 0, 1};
    tbl[6] = '{0, 0, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 2'd0, 0, 1};
    tbl[7] = '{1, 0, 16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 2'd0, 1, 0};
    tbl[8] = '{0, 1, 16'h0001, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0, 2'd1, 1, 0};
    rst = 1;
    start = 0;
    din_valid = 0;
    din = '0;
    model_reset();
    #12;
    chk_all();
    @(negedge clk);
    rst = 0;
    foreach (tbl[i]) begin
      start = tbl[i].st;
      din_valid = tbl[i].v;
      din = tbl[i].d;
      @(posedge clk);
      model_edge(tbl[i].st, tbl[i].v, tbl[i].d);
      #1;
      chk("tbl_y0", y0, tbl[i].y0);
      chk("tbl_y1", y1, tbl[i].y1);
      chk("tbl_y2", y2, tbl[i].y2);
      chk("tbl_y3", y3, tbl[i].y3);
      chk("tbl_fv", W'(frame_valid), W'(tbl[i].fv));
      chk("tbl_s", W'(s), W'(tbl[i].s));
      chk("tbl_busy", W'(busy), W'(tbl[i].busy));
      chk("tbl_err", W'(err), W'(tbl[i].err));
    end
    // gapped samples, 0..5 idle cycles between valids
    for (int g = 0; g < 6; g++) begin
      step(1, 1, 16'h1111);
      repeat (g) step(0, 0, 16'hFFFF);
      step(0, 1, 16'h2222);
      repeat (g) step(0, 0, 16'hFFFF);
      step(0, 1, 16'h3333);
      repeat (g) step(0, 0, 16'hFFFF);
      step(0, 1, 16'h4444);
      chk("gap_fv", W'(frame_valid), W'(1));
      chk("gap_y0", y0, 16'h1111);
      chk("gap_y3", y3, 16'h4444);
    end
    // abort after two samples
    step(1, 1, 16'hAAAA);
    step(0, 1, 16'hBBBB);
    step(1, 1, 16'h0001);
    chk("abort_fv", W'(frame_valid), W'(0));
    step(0, 1, 16'h0002);
    step(0, 1, 16'h0003);
    step(0, 1, 16'h0004);
    chk("abort_fv_done", W'(frame_valid), W'(1));
    chk("abort_y0", y0, 16'h0001);
    chk("abort_y1", y1, 16'h0002);
    step(0, 0, 16'h0);
    chk("abort_fv_pulse", W'(frame_valid), W'(0));
    // start coinciding with slot-3 sample
    step(1, 1, 16'h0011);
    step(0, 1, 16'h0022);
    step(0, 1, 16'h0033);
    step(1, 1, 16'h5555);
    chk("coin_fv", W'(frame_valid), W'(0));
    chk("coin_s", W'(s), W'(1));
    chk("coin_busy", W'(busy), W'(1));
    chk("coin_y0", y0, 16'h0001);
    chk("coin_y3", y3, 16'h0004);
    // async reset during slot 2
    step(0, 1, 16'h0066);
    @(negedge clk);
    rst = 1;
    #1;
    model_reset();
    chk("arst_y0", y0, 16'h0);
    chk("arst_y3", y3, 16'h0);
    chk("arst_s", W'(s), W'(0));
    chk("arst_busy", W'(busy), W'(0));
    start = 1;
    din_valid = 1;
    @(posedge clk);
    #1;
    chk("arst_ignore_start", W'(busy), W'(0));
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) step(0, 1, W'(16'h7000 + i));
    chk("arst_no_fv", W'(frame_valid), W'(0));
    chk("arst_err", W'(err), W'(1));
    // random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom % 8) == 0, $urandom % 3 != 0, W'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
